// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory transaction issuer and its status poller.
// Holds the FSM state enum and the default counter/address widths.
package mem_if_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } txn_state_e;

endpackage

// File: rtl/txn_watchdog.sv
// Cycle watchdog: counts while run is high and fires expired on the LIMIT-th cycle.
// Only instantiated when TXN_TIMEOUT_EN is defined.
module txn_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over run; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {W{1'b0}};
    end else if (run) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && !clear && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_txn_issuer.sv
// Issues a batch of SPI transactions one at a time and publishes completed/total progress.
// Optional watchdog on the WAIT state is enabled with the TXN_TIMEOUT_EN macro.
module mem_txn_issuer
  import mem_if_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned STRIDE         = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_total,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  output logic              spi_start,
  output logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_done,
  output logic [CNT_W-1:0]  out_transactions_completed,
  output logic [CNT_W-1:0]  total_transactions,
  output logic              err_timeout
);

  txn_state_e        state_q, state_d;
  logic [CNT_W-1:0]  comp_q, comp_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  comp_inc;
  logic              wd_expired;

  assign comp_inc = comp_q + CNT_W'(1);

`ifdef TXN_TIMEOUT_EN
  txn_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state_q != ST_WAIT) || spi_done),
    .run     (state_q == ST_WAIT),
    .expired (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
`endif

  // Next-state and register updates; spi_done only matters in WAIT.
  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    total_d = total_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          total_d = cmd_total;
          comp_d  = {CNT_W{1'b0}};
          addr_d  = cmd_base_addr;
          err_d   = 1'b0;
          state_d = (cmd_total == {CNT_W{1'b0}}) ? ST_IDLE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_done) begin
          comp_d  = comp_inc;
          addr_d  = addr_q + ADDR_W'(STRIDE);
          state_d = (comp_inc == total_q) ? ST_IDLE : ST_ISSUE;
        end else if (wd_expired) begin
          // Collapse total onto the completed count so the poller sees done.
          err_d   = 1'b1;
          total_d = comp_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      comp_q  <= {CNT_W{1'b0}};
      total_q <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready                  = (state_q == ST_IDLE);
  assign spi_start                  = (state_q == ST_ISSUE);
  assign spi_addr                   = addr_q;
  assign out_transactions_completed = comp_q;
  assign total_transactions         = total_q;
  assign err_timeout                = err_q;

endmodule

// File: tb/tb_mem_txn_issuer.sv
// Self-checking bench for mem_txn_issuer: behavioural progress model plus directed literal checks.
// Watchdog scenario runs only when TXN_TIMEOUT_EN is defined.
module tb_mem_txn_issuer;

  localparam int unsigned CW = 16;
  localparam int unsigned AW = 24;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_total = '0;
  logic [AW-1:0] cmd_base_addr = '0;
  logic          spi_start;
  logic [AW-1:0] spi_addr;
  logic          spi_done = 1'b0;
  logic [CW-1:0] out_transactions_completed;
  logic [CW-1:0] total_transactions;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  mem_txn_issuer #(
    .CNT_W(CW), .ADDR_W(AW), .STRIDE(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_total(cmd_total), .cmd_base_addr(cmd_base_addr),
    .spi_start(spi_start), .spi_addr(spi_addr), .spi_done(spi_done),
    .out_transactions_completed(out_transactions_completed),
    .total_transactions(total_transactions), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy = batch in progress, launch = a start is due this cycle.
  bit            m_busy = 1'b0;
  bit            m_launch = 1'b0;
  logic [CW-1:0] m_comp = '0;
  logic [CW-1:0] m_total = '0;
  logic [AW-1:0] m_addr = '0;
  bit            m_err = 1'b0;
  int            m_wait = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_launch <= 1'b0; m_comp <= '0; m_total <= '0;
      m_addr <= '0; m_err <= 1'b0; m_wait <= 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_total  <= cmd_total;
        m_comp   <= '0;
        m_addr   <= cmd_base_addr;
        m_err    <= 1'b0;
        m_busy   <= (cmd_total != 0);
        m_launch <= (cmd_total != 0);
      end
    end else if (m_launch) begin
      m_launch <= 1'b0;
      m_wait   <= 0;
    end else if (spi_done) begin
      m_comp <= m_comp + 1;
      m_addr <= m_addr + 1;
      m_wait <= 0;
      if (int'(m_comp) + 1 == int'(m_total)) m_busy <= 1'b0;
      else m_launch <= 1'b1;
    end else begin
`ifdef TXN_TIMEOUT_EN
      if (m_wait + 1 == TO) begin
        m_err   <= 1'b1;
        m_total <= m_comp;
        m_busy  <= 1'b0;
      end else begin
        m_wait <= m_wait + 1;
      end
`else
      m_wait <= m_wait + 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_ready", {31'd0, cmd_ready}, {31'd0, !m_busy});
      check("model_start", {31'd0, spi_start}, {31'd0, m_launch});
      check("model_addr", {8'd0, spi_addr}, {8'd0, m_addr});
      check("model_comp", {16'd0, out_transactions_completed}, {16'd0, m_comp});
      check("model_total", {16'd0, total_transactions}, {16'd0, m_total});
      check("model_err", {31'd0, err_timeout}, {31'd0, m_err});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue_cmd(input logic [CW-1:0] tot, input logic [AW-1:0] base);
    cmd_valid = 1'b1; cmd_total = tot; cmd_base_addr = base;
    step();
    cmd_valid = 1'b0;
  endtask

  // Waits for a start, checks its address, answers with done two cycles later.
  task automatic do_txn(input logic [AW-1:0] exp_addr, input logic [CW-1:0] exp_comp);
    int n = 0;
    while (spi_start !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("start_seen", {31'd0, spi_start}, 32'd1);
    check("start_addr", {8'd0, spi_addr}, {8'd0, exp_addr});
    step();
    step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check("comp_after_done", {16'd0, out_transactions_completed}, {16'd0, exp_comp});
  endtask

  initial begin
    step(); step();
    check_en = 1'b1;
    rst = 1'b0;
    step();
    check("reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_comp", {16'd0, out_transactions_completed}, 32'd0);

    // Three-transaction batch from 0x100.
    issue_cmd(16'd3, 24'h000100);
    check("first_start_latency", {31'd0, spi_start}, 32'd1);
    do_txn(24'h000100, 16'd1);
    do_txn(24'h000101, 16'd2);
    do_txn(24'h000102, 16'd3);
    check("batch3_ready", {31'd0, cmd_ready}, 32'd1);
    check("batch3_total", {16'd0, total_transactions}, 32'd3);

    // Empty batch is immediately done.
    issue_cmd(16'd0, 24'h000055);
    check("zero_ready", {31'd0, cmd_ready}, 32'd1);
    check("zero_start", {31'd0, spi_start}, 32'd0);
    check("zero_total", {16'd0, total_transactions}, 32'd0);
    check("zero_comp", {16'd0, out_transactions_completed}, 32'd0);
    step();
    check("zero_no_start", {31'd0, spi_start}, 32'd0);

    // Address wrap.
    issue_cmd(16'd2, 24'hFFFFFF);
    do_txn(24'hFFFFFF, 16'd1);
    do_txn(24'h000000, 16'd2);

    // Stray done in IDLE, done coincident with start, cmd_valid in WAIT.
    spi_done = 1'b1; step(); spi_done = 1'b0;
    check("idle_done_ignored", {16'd0, out_transactions_completed}, 32'd2);
    issue_cmd(16'd2, 24'h000200);
    spi_done = 1'b1; step(); spi_done = 1'b0;
    check("issue_done_ignored", {16'd0, out_transactions_completed}, 32'd0);
    issue_cmd(16'd7, 24'h000999);
    check("wait_cmd_ignored", {16'd0, total_transactions}, 32'd2);
    check("wait_not_ready", {31'd0, cmd_ready}, 32'd0);
    spi_done = 1'b1; step(); spi_done = 1'b0;
    check("wait_done_counted", {16'd0, out_transactions_completed}, 32'd1);
    do_txn(24'h000201, 16'd2);

    // Reset mid-batch.
    issue_cmd(16'd4, 24'h000300);
    do_txn(24'h000300, 16'd1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_start", {31'd0, spi_start}, 32'd0);
    check("rst_comp", {16'd0, out_transactions_completed}, 32'd0);
    check("rst_total", {16'd0, total_transactions}, 32'd0);
    check("rst_addr", {8'd0, spi_addr}, 32'd0);
    spi_done = 1'b1; step(); spi_done = 1'b0;
    check("rst_stray_done", {16'd0, out_transactions_completed}, 32'd0);
    check("rst_stray_start", {31'd0, spi_start}, 32'd0);

`ifdef TXN_TIMEOUT_EN
    issue_cmd(16'd5, 24'h000400);
    do_txn(24'h000400, 16'd1);
    repeat (16) step();
    check("to_not_yet", {31'd0, err_timeout}, 32'd0);
    step();
    check("to_err", {31'd0, err_timeout}, 32'd1);
    check("to_total", {16'd0, total_transactions}, 32'd1);
    check("to_comp", {16'd0, out_transactions_completed}, 32'd1);
    check("to_ready", {31'd0, cmd_ready}, 32'd1);
    issue_cmd(16'd1, 24'h000500);
    check("to_cleared", {31'd0, err_timeout}, 32'd0);
    do_txn(24'h000500, 16'd1);
`else
    check("no_wd_err", {31'd0, err_timeout}, 32'd0);
`endif

    step(); step();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
